// File: rtl/krnl_partialknn_mem_pkg.sv
// Shared types, constants and lane-merge helper for the partialKnn URAM.
// Used by krnl_partialknn_uram_pipe_1r1w and krnl_partialknn_uram_bank.
package krnl_partialknn_mem_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } clr_state_e;

  localparam int MAX_READ_LATENCY = 4;

  // Widest word and lane count the merge helper can handle
  localparam int KNN_MAX_DW    = 2048;
  localparam int KNN_MAX_LANES = 64;
  localparam int KNN_BIT_IW    = $clog2(KNN_MAX_DW);
  localparam int KNN_LANE_IW   = $clog2(KNN_MAX_LANES);

  typedef logic [KNN_MAX_DW-1:0] knn_word_t;

  localparam knn_word_t CLEAR_VALUE = '0;

  function automatic knn_word_t lane_merge(
    knn_word_t                old_w,
    knn_word_t                new_w,
    logic [KNN_MAX_LANES-1:0] mask,
    int                       lane_w
  );
    knn_word_t r;
    r = old_w;
    for (int b = 0; b < KNN_MAX_DW; b++) begin
      if (mask[KNN_LANE_IW'(b / lane_w)])
        r[KNN_BIT_IW'(b)] = new_w[KNN_BIT_IW'(b)];
    end
    return r;
  endfunction

endpackage

// File: rtl/krnl_partialknn_uram_bank.sv
// Bare 1R1W URAM array: per-lane masked write, read-first,
// one-cycle registered read that holds between reads.
module krnl_partialknn_uram_bank
  import krnl_partialknn_mem_pkg::*;
#(
  parameter int LANE_WIDTH = 32,
  parameter int NUM_LANES  = 8,
  parameter int DEPTH      = 2048,
  parameter int AW         = 11
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_re,
  input  logic [AW-1:0]                   i_raddr,
  output logic [LANE_WIDTH*NUM_LANES-1:0] o_rdata,
  input  logic [NUM_LANES-1:0]            i_we,
  input  logic [AW-1:0]                   i_waddr,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] i_wdata
);

  localparam int DW = LANE_WIDTH * NUM_LANES;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (i_we[l])
        r_mem[i_waddr][l*LANE_WIDTH +: LANE_WIDTH] <=
          i_wdata[l*LANE_WIDTH +: LANE_WIDTH];
    end
  end

  // Only the output register is reset; the array is zeroed by the clear FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/krnl_partialknn_uram_pipe_1r1w.sv
// partialKnn URAM scratch: clear FSM, pipelined read, range check.
// Define KNN_URAM_WRITE_FORWARD_EN for write-first forwarding.
module krnl_partialknn_uram_pipe_1r1w
  import krnl_partialknn_mem_pkg::*;
#(
  parameter int LANE_WIDTH   = 32,
  parameter int NUM_LANES    = 8,
  parameter int AddressRange = 2048,
  parameter int AddressWidth = 11,
  parameter int READ_LATENCY = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [AddressWidth-1:0]         address0,
  input  logic                            ce0,
  output logic [LANE_WIDTH*NUM_LANES-1:0] q0,
  output logic                            q0_valid,
  input  logic [AddressWidth-1:0]         address1,
  input  logic                            ce1,
  input  logic [NUM_LANES-1:0]            we1,
  input  logic [LANE_WIDTH*NUM_LANES-1:0] d1,
  output logic                            init_done
);

  localparam int          DW = LANE_WIDTH * NUM_LANES;
  localparam int          AW = AddressWidth;
  localparam int          NS = READ_LATENCY - 1;
  localparam logic [31:0] AR = 32'(AddressRange);

  clr_state_e r_state, w_state_nxt;
  logic [AW-1:0] r_clr_cnt;
  logic r_init_done;

  logic w_run, w_rd_in, w_wr_in, w_rd_fire, w_wr_fire, w_bk_re;
  logic [NUM_LANES-1:0] w_bk_we;
  logic [AW-1:0] w_bk_waddr;
  logic [DW-1:0] w_bk_wdata, w_bk_q, w_s0_dat;

  logic r_s0_vld, r_s0_oor;

`ifdef KNN_URAM_WRITE_FORWARD_EN
  logic [AW-1:0] r_s0_adr;
  logic [NUM_LANES-1:0] r_s0_fmsk;
  logic [DW-1:0] r_s0_fdat;

  function automatic logic [DW-1:0] fwd_merge(
    logic [DW-1:0]        o,
    logic [DW-1:0]        n,
    logic [NUM_LANES-1:0] m
  );
    knn_word_t w_r;
    w_r = lane_merge(KNN_MAX_DW'(o), KNN_MAX_DW'(n),
                     KNN_MAX_LANES'(m), LANE_WIDTH);
    return w_r[DW-1:0];
  endfunction
`endif

  assign w_run     = (r_state == RUN);
  assign w_rd_in   = 32'(address0) < AR;
  assign w_wr_in   = 32'(address1) < AR;
  assign w_rd_fire = w_run & ce0;
  assign w_wr_fire = w_run & ce1 & w_wr_in;
  assign w_bk_re   = w_rd_fire & w_rd_in;
  assign init_done = r_init_done;

  always_comb begin
    w_state_nxt = r_state;
    w_bk_we     = '0;
    w_bk_waddr  = address1;
    w_bk_wdata  = d1;
    unique case (r_state)
      INIT: begin
        w_bk_we    = '1;
        w_bk_waddr = r_clr_cnt;
        w_bk_wdata = DW'(CLEAR_VALUE);
        if (32'(r_clr_cnt) == AR - 32'd1)
          w_state_nxt = RUN;
      end
      RUN: begin
        if (w_wr_fire)
          w_bk_we = we1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT;
      r_clr_cnt   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == RUN);
      if (r_state == INIT)
        r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  krnl_partialknn_uram_bank #(
    .LANE_WIDTH (LANE_WIDTH),
    .NUM_LANES  (NUM_LANES),
    .DEPTH      (AddressRange),
    .AW         (AddressWidth)
  ) u_bank (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_re    (w_bk_re),
    .i_raddr (address0),
    .o_rdata (w_bk_q),
    .i_we    (w_bk_we),
    .i_waddr (w_bk_waddr),
    .i_wdata (w_bk_wdata)
  );

  // Stage 0 tracks the bank read; a same-cycle write is captured here
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0_vld  <= 1'b0;
      r_s0_oor  <= 1'b0;
`ifdef KNN_URAM_WRITE_FORWARD_EN
      r_s0_adr  <= '0;
      r_s0_fmsk <= '0;
      r_s0_fdat <= '0;
`endif
    end else begin
      r_s0_vld <= w_rd_fire;
      if (w_rd_fire) begin
        r_s0_oor  <= !w_rd_in;
`ifdef KNN_URAM_WRITE_FORWARD_EN
        r_s0_adr  <= address0;
        r_s0_fmsk <= (w_wr_fire && address1 == address0) ? we1 : '0;
        r_s0_fdat <= d1;
`endif
      end
    end
  end

  always_comb begin
    w_s0_dat = w_bk_q;
`ifdef KNN_URAM_WRITE_FORWARD_EN
    w_s0_dat = fwd_merge(w_bk_q, r_s0_fdat, r_s0_fmsk);
`endif
    if (r_s0_oor)
      w_s0_dat = '0;
  end

  generate
    if (NS == 0) begin : g_lat1
      assign q0       = w_s0_dat;
      assign q0_valid = r_s0_vld;
    end else begin : g_pipe
      logic          r_vld    [NS];
      logic [DW-1:0] r_dat    [NS];
      logic          w_in_vld [NS];
      logic [DW-1:0] w_in_dat [NS];
`ifdef KNN_URAM_WRITE_FORWARD_EN
      logic [AW-1:0] r_adr    [NS];
      logic [AW-1:0] w_in_adr [NS];
`endif

      always_comb begin
        w_in_vld[0] = r_s0_vld;
        w_in_dat[0] = w_s0_dat;
`ifdef KNN_URAM_WRITE_FORWARD_EN
        w_in_adr[0] = r_s0_adr;
`endif
        for (int i = 1; i < NS; i++) begin
          w_in_vld[i] = r_vld[i-1];
          w_in_dat[i] = r_dat[i-1];
`ifdef KNN_URAM_WRITE_FORWARD_EN
          w_in_adr[i] = r_adr[i-1];
`endif
        end
      end

      always_ff @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
          if (reset) begin
            r_vld[i] <= 1'b0;
            r_dat[i] <= '0;
`ifdef KNN_URAM_WRITE_FORWARD_EN
            r_adr[i] <= '0;
`endif
          end else begin
            r_vld[i] <= w_in_vld[i];
            if (w_in_vld[i]) begin
`ifdef KNN_URAM_WRITE_FORWARD_EN
              r_adr[i] <= w_in_adr[i];
              r_dat[i] <= fwd_merge(w_in_dat[i], d1,
                (w_wr_fire && address1 == w_in_adr[i]) ? we1 : '0);
`else
              r_dat[i] <= w_in_dat[i];
`endif
            end
          end
        end
      end

      assign q0       = r_dat[NS-1];
      assign q0_valid = r_vld[NS-1];
    end
  endgenerate

endmodule

// File: tb/tb_krnl_partialknn_uram_pipe_1r1w.sv
// Randomized + directed bench for krnl_partialknn_uram_pipe_1r1w
// against a behavioural memory model.
module tb_krnl_partialknn_uram_pipe_1r1w;

  localparam int LW = 32;
  localparam int NL = 8;
  localparam int DW = LW * NL;
  localparam int AR = 1500;
  localparam int AW = 11;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address0 = '0;
  logic          ce0 = 1'b0;
  logic [DW-1:0] q0;
  logic          q0_valid;
  logic [AW-1:0] address1 = '0;
  logic          ce1 = 1'b0;
  logic [NL-1:0] we1 = '0;
  logic [DW-1:0] d1 = '0;
  logic          init_done;

  always #5 clk = ~clk;

  krnl_partialknn_uram_pipe_1r1w #(
    .LANE_WIDTH   (LW),
    .NUM_LANES    (NL),
    .AddressRange (AR),
    .AddressWidth (AW),
    .READ_LATENCY (RL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address0  (address0),
    .ce0       (ce0),
    .q0        (q0),
    .q0_valid  (q0_valid),
    .address1  (address1),
    .ce1       (ce1),
    .we1       (we1),
    .d1        (d1),
    .init_done (init_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic chk_b(string nm, logic act, logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  task automatic chk_i(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int            addr;
    int            due;
    logic [DW-1:0] snap;
  } rd_t;

  logic [DW-1:0] m_mem [AR];
  rd_t           pend [$];
  int            cyc = 0;
  int            clr_cnt = 0;
  bit            m_run = 1'b0;
  logic          m_vld = 1'b0;
  logic [DW-1:0] m_q = '0;

  function automatic logic [DW-1:0] mmerge(logic [DW-1:0] o,
                                           logic [DW-1:0] n,
                                           logic [NL-1:0] m);
    logic [DW-1:0] r;
    r = o;
    for (int l = 0; l < NL; l++)
      if (m[l]) r[l*LW +: LW] = n[l*LW +: LW];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        pend.delete();
        clr_cnt = 0;
        m_run = 1'b0;
        m_vld = 1'b0;
        m_q = '0;
        foreach (m_mem[k]) m_mem[k] = '0;
      end else begin
        if (m_run) begin
          if (ce0) begin
            rd_t r;
            r.addr = int'(address0);
            r.due  = cyc + RL - 1;
            r.snap = (r.addr < AR) ? m_mem[r.addr] : '0;
            pend.push_back(r);
          end
          if (ce1 && int'(address1) < AR)
            m_mem[int'(address1)] = mmerge(m_mem[int'(address1)], d1, we1);
        end else begin
          clr_cnt++;
          if (clr_cnt == AR) m_run = 1'b1;
        end
        m_vld = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          rd_t r;
          r = pend.pop_front();
          m_vld = 1'b1;
`ifdef KNN_URAM_WRITE_FORWARD_EN
          m_q = (r.addr < AR) ? m_mem[r.addr] : '0;
`else
          m_q = r.snap;
`endif
        end
      end
      #1;
      chk_b("q0_valid", q0_valid, m_vld);
      chk("q0", q0, m_q);
      chk_b("init_done", init_done, m_run);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drv(bit re, int ra, bit wen, int wa,
                     logic [DW-1:0] wd, logic [NL-1:0] wm);
    @(negedge clk);
    ce0      = re;
    address0 = AW'(ra);
    ce1      = wen;
    address1 = AW'(wa);
    d1       = wd;
    we1      = wm;
  endtask

  task automatic idle();
    drv(1'b0, 0, 1'b0, 0, '0, '0);
  endtask

  task automatic wr(int a, logic [DW-1:0] d, logic [NL-1:0] m);
    drv(1'b0, 0, 1'b1, a, d, m);
  endtask

  task automatic rd_get(int a,
                        bit w0, int wa0, logic [DW-1:0] wd0, logic [NL-1:0] wm0,
                        bit w1, int wa1, logic [DW-1:0] wd1, logic [NL-1:0] wm1,
                        output logic [DW-1:0] q, output int lat);
    drv(1'b1, a, w0, wa0, wd0, wm0);
    drv(1'b0, 0, w1, wa1, wd1, wm1);
    lat = -1;
    q = '0;
    for (int k = 1; k <= 8; k++) begin
      if (q0_valid) begin
        lat = k;
        q = q0;
        break;
      end
      idle();
    end
    idle();
  endtask

  task automatic rd_chk(string nm, int a, logic [DW-1:0] exp);
    logic [DW-1:0] q;
    int lat;
    rd_get(a, 1'b0, 0, '0, '0, 1'b0, 0, '0, '0, q, lat);
    chk_i({nm, " latency"}, lat, RL);
    chk({nm, " data"}, q, exp);
  endtask

  task automatic release_wait(string nm, output int pulses);
    int n;
    reset = 1'b0;
    n = 0;
    pulses = 0;
    while (!init_done && n < AR + 20) begin
      @(negedge clk);
      n++;
      if (q0_valid) pulses++;
    end
    chk_i({nm, " init cycles"}, n, AR);
  endtask

  function automatic int pick();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 15));
    return int'($urandom_range(AR - 5, AR + 5));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] q;
    int lat;
    int pulses;

    repeat (3) @(negedge clk);
    release_wait("reset", pulses);

    rd_chk("clr 0", 0, '0);
    rd_chk("clr 1023", 1023, '0);
    rd_chk("clr 2047", 2047, '0);

    wr(5, {8{32'h11111111}}, 8'hFF);
    wr(5, {8{32'h22222222}}, 8'h0F);
    idle();
    rd_chk("masked", 5, {{4{32'h11111111}}, {4{32'h22222222}}});

    for (int i = 0; i < 10; i++) wr(i, DW'(i), 8'hFF);
    idle();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        chk_b("pipe valid", q0_valid, 1'b1);
        chk("pipe data", q0, DW'(i - 2));
      end
      ce0 = (i < 10);
      address0 = AW'(i);
    end
    @(negedge clk);
    chk_b("pipe drained", q0_valid, 1'b0);

    wr(7, DW'(32'hAA), 8'hFF);
    wr(8, DW'(32'hCC), 8'hFF);
    idle();
    rd_get(7, 1'b1, 7, DW'(32'hBB), 8'hFF, 1'b0, 0, '0, '0, q, lat);
`ifdef KNN_URAM_WRITE_FORWARD_EN
    chk("collide same", q, DW'(32'hBB));
`else
    chk("collide same", q, DW'(32'hAA));
`endif
    rd_get(8, 1'b0, 0, '0, '0, 1'b1, 8, DW'(32'hDD), 8'hFF, q, lat);
`ifdef KNN_URAM_WRITE_FORWARD_EN
    chk("collide next", q, DW'(32'hDD));
`else
    chk("collide next", q, DW'(32'hCC));
`endif
    rd_get(9, 1'b1, 9, {8{32'h55555555}}, 8'h0F,
              1'b1, 9, {8{32'h66666666}}, 8'h03, q, lat);
`ifdef KNN_URAM_WRITE_FORWARD_EN
    chk("collide lanes", q, {{4{32'h0}}, {2{32'h55555555}}, {2{32'h66666666}}});
`else
    chk("collide lanes", q, DW'(9));
`endif

    for (int n = 0; n < 3000; n++) begin
      drv(1'($urandom_range(0, 1)), pick(),
          1'($urandom_range(0, 2) != 0), pick(),
          {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()},
          NL'($urandom()));
    end
    repeat (4) idle();

    wr(1600, DW'(32'hFF), 8'hFF);
    idle();
    rd_chk("oor 1600", 1600, '0);
    rd_chk("oor 1599", 1599, '0);

    wr(3, DW'(32'h123), 8'hFF);
    idle();
    rd_chk("pre-reset", 3, DW'(32'h123));
    drv(1'b1, 3, 1'b0, 0, '0, '0);
    drv(1'b1, 3, 1'b0, 0, '0, '0);
    drv(1'b1, 3, 1'b0, 0, '0, '0);
    idle();
    reset = 1'b1;
    @(negedge clk);
    chk_b("mid reset init_done", init_done, 1'b0);
    chk_b("mid reset q0_valid", q0_valid, 1'b0);
    release_wait("mid reset", pulses);
    chk_i("mid reset pulses", pulses, 0);
    rd_chk("post clear", 3, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
